// File: rtl/tb_cheshire_irq_gen.sv
// tb_cheshire_irq_gen -- periodic interrupt generator for driving external IRQ
// lines of a SoC under test.
//
// Every max(period_i,1) cycles of counting, one line (round-robin over
// NumIrq) fires. Pulse mode (level_i=0) gives a single-cycle pulse; level mode
// (level_i=1) holds the line until the matching ack_i bit is sampled.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   en_i      generator enable; low forces idle on the next cycle
//   level_i   mode select, sampled when the counter expires
//   period_i  reload period in cycles, sampled at each reload
//   ack_i     per-line acknowledge (level mode, current line only)
//   irq_o     registered interrupt lines, one-hot or zero
//   idx_o     index of the next/current line to fire
//   fired_o   saturating count of interrupts fired
//
// Optional feature: define TB_CHESHIRE_IRQ_JITTER_EN to add an 8-bit LFSR
// (taps 8,6,5,4, seed 0x5A) whose low 3 bits are added to every reload value.
module tb_cheshire_irq_gen #(
  parameter int unsigned NumIrq   = 4,
  parameter int unsigned CntWidth = 16,
  localparam int unsigned IdxW    = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                level_i,
  input  logic [CntWidth-1:0] period_i,
  input  logic [NumIrq-1:0]   ack_i,
  output logic [NumIrq-1:0]   irq_o,
  output logic [IdxW-1:0]     idx_o,
  output logic [31:0]         fired_o
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FIRE,
    WAIT_ACK
  } state_e;

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic [NumIrq-1:0]   irq_q;
  logic [IdxW-1:0]     idx_q;
  logic [31:0]         fired_q;

  logic [CntWidth-1:0] reload;
  logic [IdxW-1:0]     idx_nxt;
  logic [NumIrq-1:0]   onehot;
  logic                ack_hit;

  always_comb begin
    idx_nxt = (idx_q == IdxW'(NumIrq - 1)) ? '0 : idx_q + IdxW'(1);
    onehot  = '0;
    onehot[idx_q] = 1'b1;
    ack_hit = ack_i[idx_q];
  end

`ifdef TB_CHESHIRE_IRQ_JITTER_EN
  logic [7:0] lfsr_q;
  logic       reload_take;

  // The LFSR advances exactly when the counter is reloaded, so the jitter
  // sequence is tied to reload events rather than to elapsed cycles.
  always_comb begin
    reload_take = en_i && ((state_q == IDLE) || (state_q == FIRE) ||
                           ((state_q == WAIT_ACK) && ack_hit));
    reload = ((period_i == '0) ? '0 : period_i - CntWidth'(1)) +
             CntWidth'(lfsr_q[2:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 8'h5A;
    end else if (reload_take) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end
`else
  always_comb begin
    reload = (period_i == '0) ? '0 : period_i - CntWidth'(1);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= '0;
      idx_q   <= '0;
      fired_q <= '0;
    end else if (!en_i) begin
      // Disable wins over ack/expiry; idx and fired count are preserved.
      state_q <= IDLE;
      irq_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q   <= reload;
          state_q <= COUNT;
        end
        COUNT: begin
          if (cnt_q == '0) begin
            state_q <= level_i ? WAIT_ACK : FIRE;
            irq_q   <= onehot;
            if (fired_q != '1) fired_q <= fired_q + 32'd1;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        FIRE: begin
          irq_q   <= '0;
          idx_q   <= idx_nxt;
          cnt_q   <= reload;
          state_q <= COUNT;
        end
        WAIT_ACK: begin
          if (ack_hit) begin
            irq_q   <= '0;
            idx_q   <= idx_nxt;
            cnt_q   <= reload;
            state_q <= COUNT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_o   = irq_q;
  assign idx_o   = idx_q;
  assign fired_o = fired_q;

endmodule

// File: tb/tb_tb_cheshire_irq_gen.sv
// Bench for tb_cheshire_irq_gen: directed scenarios with literal expectations
// plus a deadline-based reference model compared on every falling edge.
module tb_tb_cheshire_irq_gen;

  localparam int unsigned NumIrq   = 4;
  localparam int unsigned CntWidth = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                level = 1'b0;
  logic [CntWidth-1:0] period = '0;
  logic [NumIrq-1:0]   ack = '0;
  logic [NumIrq-1:0]   irq;
  logic [1:0]          idx;
  logic [31:0]         fired;

  tb_cheshire_irq_gen #(.NumIrq(NumIrq), .CntWidth(CntWidth)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .level_i (level),
    .period_i(period),
    .ack_i   (ack),
    .irq_o   (irq),
    .idx_o   (idx),
    .fired_o (fired)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;
  bit          cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the absolute edge number at which the current
  // line must rise, instead of a down-counter.
  longint unsigned now = 0;
  bit              m_act = 0;
  bit              m_hi = 0;
  bit              m_lvl = 0;
  longint unsigned m_rise = 0;
  int unsigned     m_line = 0;
  longint unsigned m_fired = 0;
  logic [7:0]      m_lfsr = 8'h5A;

  function automatic longint unsigned delay_now();
    longint unsigned d;
    d = (period == 0) ? 1 : longint'(period);
`ifdef TB_CHESHIRE_IRQ_JITTER_EN
    d = d + (m_lfsr & 8'h07);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
    return d;
  endfunction

  task automatic model_step();
    now++;
    if (rst) begin
      m_act = 0; m_hi = 0; m_line = 0; m_fired = 0; m_lfsr = 8'h5A;
    end else if (!en) begin
      m_act = 0; m_hi = 0;
    end else if (!m_act) begin
      m_act = 1;
      m_rise = now + delay_now();
    end else if (m_hi) begin
      if (!m_lvl || ack[m_line]) begin
        m_hi = 0;
        m_line = (m_line + 1) % NumIrq;
        m_rise = now + delay_now();
      end
    end else if (now == m_rise) begin
      m_hi = 1;
      m_lvl = level;
      if (m_fired < 64'hFFFF_FFFF) m_fired++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_irq", 64'(irq), m_hi ? 64'(1) << m_line : 64'd0);
      chk("model_idx", 64'(idx), 64'(m_line));
      chk("model_fired", 64'(fired), m_fired);
    end
  end

  task automatic waitn(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit seen;
    // Reset state
    waitn(2);
    cmp_on = 1'b1;
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_fired", 64'(fired), 64'd0);

    // Pulse mode, period 5: pulses every 6 cycles, round robin
    rst = 0; en = 1; level = 0; period = 5;
    waitn(6); chk("pulse0", 64'(irq), 64'b0001);
    waitn(1); chk("pulse0_off", 64'(irq), 64'b0000);
    period = 9;  // mid-count change ignored until the next reload
    waitn(5); chk("pulse1", 64'(irq), 64'b0010);
    period = 5;
    waitn(6); chk("pulse2", 64'(irq), 64'b0100);
    waitn(6); chk("pulse3", 64'(irq), 64'b1000);
    waitn(6); chk("pulse4", 64'(irq), 64'b0001);
    chk("pulse_fired", 64'(fired), 64'd5);
    en = 0;
    waitn(1); chk("dis_irq", 64'(irq), 64'd0);
    chk("dis_idx", 64'(idx), 64'd0);
    chk("dis_fired", 64'(fired), 64'd5);

    // Level mode, period 3, with stray acks
    rst = 1; waitn(1);
    rst = 0; level = 1; period = 3; en = 1;
    waitn(2); ack = 4'b0100;
    waitn(1); ack = 4'b0000;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (irq[0]) begin seen = 1; break; end
      waitn(1);
    end
    chk("lvl_rise_seen", 64'(seen), 64'd1);
    ack = 4'b0100;
    waitn(2); chk("lvl_stray", 64'(irq), 64'b0001);
    ack = 4'b0000;
    waitn(2); ack = 4'b0001;
    waitn(1); chk("lvl_clear", 64'(irq), 64'b0000);
    chk("lvl_idx", 64'(idx), 64'd1);
    ack = 4'b0000;
    waitn(3); chk("lvl_next", 64'(irq), 64'b0010);

    // Disable together with the matching ack: idle, same line next
    en = 0; ack = 4'b0010;
    waitn(1); chk("disack_irq", 64'(irq), 64'd0);
    chk("disack_idx", 64'(idx), 64'd1);
    en = 1; ack = 4'b0000;
    waitn(4); chk("reen_irq", 64'(irq), 64'b0010);
    chk("reen_fired", 64'(fired), 64'd3);
    ack = 4'b0010;
    waitn(1); ack = 4'b0000;
    waitn(3); chk("lvl_line2", 64'(irq), 64'b0100);

    // Reset while a level interrupt is held
    rst = 1;
    waitn(1); chk("midrst_irq", 64'(irq), 64'd0);
    chk("midrst_idx", 64'(idx), 64'd0);
    chk("midrst_fired", 64'(fired), 64'd0);
    rst = 0; en = 0;
    waitn(1);

    // period 0 behaves as period 1
    period = 0; level = 0; en = 1;
    waitn(2); chk("p0_first", 64'(irq), 64'b0001);
    waitn(1); chk("p0_gap", 64'(irq), 64'b0000);
    waitn(1); chk("p0_second", 64'(irq), 64'b0010);

    // Mixed stimulus checked by the model only
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      period = CntWidth'($urandom_range(0, 4));
      level  = 1'($urandom_range(0, 1));
      ack    = NumIrq'($urandom);
      en     = ($urandom_range(0, 19) != 0);
      rst    = ($urandom_range(0, 99) == 0);
    end
    rst = 0;
    waitn(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
